trig_scale_pipe: RTL and testbench
==================================

Name: trig_scale_pipe

Overview:
- Pipelined, parametrised scaler computing r*sin(theta), r*cos(theta) or r*tan(theta) for theta = 15*k degrees, k = 0..23 (full circle).
- Successor to the fixed 0–90 degree combinational r*tan block.
- Sits between the ultrasound range/angle front end and the polar-to-Cartesian / display stages.
- Adds valid/ready flow control, function select, quadrant reduction, saturation and a passthrough tag.

Parameters:
- R_WIDTH, 9: signed width of input magnitude r.
- OUT_WIDTH, R_WIDTH+2: signed width of the result; headroom for tan75 ≈ 3.73.
- TAG_WIDTH, 4: width of the sideband tag carried alongside each sample.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_r  in  R_WIDTH  signed r.
- in_angle  in  5  angle index k; theta = 15*k degrees; legal values 0..23.
- in_func  in  2  function select: 0 = sin, 1 = cos, 2 = tan, 3 = reserved.
- in_tag  in  TAG_WIDTH  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  OUT_WIDTH  signed r*f(theta).
- out_tag  out  TAG_WIDTH  tag of this result.
- out_sat  out  1  result was clamped, or is tan at 90/270.
- out_err  out  1  illegal angle (k > 23) or func = 3; result forced to 0.

Behaviour:
- Reset (async, reset_n = 0):
  - All stage valid bits clear.
  - out_valid = 0, out_result = 0, out_tag = 0, out_sat = 0, out_err = 0.
  - in_ready = 1 from the first cycle after release.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline: 3 stages (S1 decode, S2 multiply, S3 shift/saturate).
  - Latency is exactly 3 cycles from input transfer to out_valid, with out_ready held high.
  - Throughput is 1 sample per cycle.
- Stall rule:
  - stall = out_valid && !out_ready.
  - While stalled, all stages hold and in_ready = 0. in_ready is combinational: !stall.
  - Bubbles are not compressed; a simple global stall is required.
- S1 decode:
  - Fold k to a base index m in 0..6 and a sign. Quadrant q = k/6, p = k mod 6.
  - sin: q0 → +sin(p); q1 → +sin(6-p); q2 → -sin(p); q3 → -sin(6-p).
  - cos(k) = sin((k+6) mod 24).
  - tan: k' = k mod 12. k' ≤ 6 → +tan(k'); k' > 6 → -tan(12-k').
  - Produces a signed Q.11 coefficient (13-bit magnitude plus sign), plus special, sat and err flags.
- S2: signed product P = r * coef, width R_WIDTH+14. The sign is applied to the coefficient before multiplying.
- S3: arithmetic shift P >>> 11 (floor toward -inf).
  - Clamp to ±(2^(OUT_WIDTH-1)-1), symmetric. Clamping sets out_sat.
- tan at 90 / 270 degrees (k = 6 or 18):
  - Result is +MAX if r > 0, -MAX if r < 0, 0 if r = 0.
  - out_sat = 1 in all three cases.
- err: out_result = 0, out_sat = 0, out_err = 1. The sample still flows and out_tag is preserved.
- Reset asserted mid-operation: in-flight samples are discarded and no output appears after release.
- Simultaneous output transfer and new input on a full pipeline: legal. Both transfers occur in the same cycle.

Decomposition:
- Shared package trig_consts, Q.11 values:
  - SIN: 0, 530, 1024, 1448, 1774, 1978, 2048.
  - TAN: 0, 549, 1182, 2048, 3547, 7643 (index 6 is special).
  - Also FRAC_BITS = 11, and the FUNC_SIN/COS/TAN/RSVD encodings.
- One sub-module, trig_coef_lookup: combinational k/func → {coef, special, err}, used in S1.
- Pipeline registers and stall logic stay in the top module.

Test Plan:
- Basic tan, out_ready = 1, R_WIDTH = 9:
  - r = 100, func = tan, k = 2 → out_result = 57 three cycles later, sat = 0.
  - k = 3 → 100.
- Quadrant folding:
  - r = 200, sin, k = 13 → -52.
  - r = 100, cos, k = 0 → 100.
  - r = 100, tan, k = 10 → -57 - 1 = -58 (floor of -57.71).
- Extremes:
  - r = 255, tan, k = 5 → 951.
  - r = -256, tan, k = 5 → -956.
  - r = -100, tan, k = 6 → -1023 with out_sat = 1.
  - r = 0, tan, k = 18 → 0 with out_sat = 1.
- Error:
  - k = 24, or func = 3, with tag 0xA → out_result = 0, out_err = 1, out_tag = 0xA.
- Backpressure: stream 10 samples with out_ready toggling pseudo-randomly.
  - Every result arrives in order with the correct tag; none dropped or duplicated.
  - in_ready is low exactly on stall cycles.
- Reset mid-stream: drop reset_n with 3 samples in flight → out_valid = 0 immediately and no stale output after release.

Source files
------------

// File: rtl/trig_consts.sv
// Shared Q.11 trig coefficients and function-select encodings for the
// trig_scale_pipe datapath.
package trig_consts;

  localparam int FRAC_BITS = 11;
  localparam int COEF_W    = 14;

  typedef enum logic [1:0] {
    FUNC_SIN  = 2'd0,
    FUNC_COS  = 2'd1,
    FUNC_TAN  = 2'd2,
    FUNC_RSVD = 2'd3
  } func_e;

  function automatic logic [12:0] sin_q11(input logic [2:0] m);
    case (m)
      3'd0:    return 13'd0;
      3'd1:    return 13'd530;
      3'd2:    return 13'd1024;
      3'd3:    return 13'd1448;
      3'd4:    return 13'd1774;
      3'd5:    return 13'd1978;
      3'd6:    return 13'd2048;
      default: return 13'd0;
    endcase
  endfunction

  // Index 6 (90 degrees) is handled as a special case by the pipeline.
  function automatic logic [12:0] tan_q11(input logic [2:0] m);
    case (m)
      3'd0:    return 13'd0;
      3'd1:    return 13'd549;
      3'd2:    return 13'd1182;
      3'd3:    return 13'd2048;
      3'd4:    return 13'd3547;
      3'd5:    return 13'd7643;
      default: return 13'd0;
    endcase
  endfunction

endpackage

// File: rtl/trig_coef_lookup.sv
// Combinational angle/function decode: folds the 24-step angle into a base
// index and sign and returns a signed Q.11 coefficient plus flags.
module trig_coef_lookup
  import trig_consts::*;
(
  input  logic [4:0]               angle,
  input  logic [1:0]               func,
  output logic signed [COEF_W-1:0] coef,
  output logic                     special,
  output logic                     err
);

  logic [4:0]  k_eff;
  logic [4:0]  tk;
  logic [2:0]  m;
  logic        neg;
  logic [12:0] mag;

  always_comb begin
    k_eff   = angle;
    tk      = '0;
    m       = '0;
    neg     = 1'b0;
    mag     = '0;
    special = 1'b0;
    err     = (angle > 5'd23) || (func == FUNC_RSVD);

    // cos(k) is sin(k + 6) modulo the full circle
    if (func == FUNC_COS) begin
      k_eff = (angle >= 5'd18) ? angle - 5'd18 : angle + 5'd6;
    end

    if (func == FUNC_TAN) begin
      tk = (angle >= 5'd12) ? angle - 5'd12 : angle;
      if (tk <= 5'd6) begin
        m = tk[2:0];
      end else begin
        m   = 3'(5'd12 - tk);
        neg = 1'b1;
      end
      special = (tk == 5'd6) && !err;
      mag     = tan_q11(m);
    end else begin
      if (k_eff < 5'd6) begin
        m = k_eff[2:0];
      end else if (k_eff < 5'd12) begin
        m = 3'(5'd12 - k_eff);
      end else if (k_eff < 5'd18) begin
        m   = 3'(k_eff - 5'd12);
        neg = 1'b1;
      end else begin
        m   = 3'(5'd24 - k_eff);
        neg = 1'b1;
      end
      mag = sin_q11(m);
    end

    coef = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/trig_scale_pipe.sv
// Three-stage r*sin/cos/tan scaler (decode, multiply, shift/saturate) with
// valid/ready flow control, a global stall and a passthrough tag.
module trig_scale_pipe
  import trig_consts::*;
#(
  parameter int R_WIDTH   = 9,
  parameter int OUT_WIDTH = R_WIDTH + 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [R_WIDTH-1:0]   in_r,
  input  logic [4:0]                  in_angle,
  input  logic [1:0]                  in_func,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        out_sat,
  output logic                        out_err
);

  localparam int PROD_W = R_WIDTH + 14;
  localparam logic signed [OUT_WIDTH-1:0] MAX_OUT = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic signed [COEF_W-1:0] lk_coef;
  logic                     lk_special, lk_err;
  logic                     stall;

  logic                      s1_valid_d, s1_valid_q;
  logic signed [R_WIDTH-1:0] s1_r_d, s1_r_q;
  logic signed [COEF_W-1:0]  s1_coef_d, s1_coef_q;
  logic                      s1_special_d, s1_special_q;
  logic                      s1_err_d, s1_err_q;
  logic [TAG_WIDTH-1:0]      s1_tag_d, s1_tag_q;

  logic                      s2_valid_d, s2_valid_q;
  logic signed [PROD_W-1:0]  s2_prod_d, s2_prod_q;
  logic                      s2_rpos_d, s2_rpos_q;
  logic                      s2_rneg_d, s2_rneg_q;
  logic                      s2_special_d, s2_special_q;
  logic                      s2_err_d, s2_err_q;
  logic [TAG_WIDTH-1:0]      s2_tag_d, s2_tag_q;

  logic                        out_valid_d, out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_result_d, out_result_q;
  logic [TAG_WIDTH-1:0]        out_tag_d, out_tag_q;
  logic                        out_sat_d, out_sat_q;
  logic                        out_err_d, out_err_q;

  logic signed [PROD_W-1:0] shifted, max_p, min_p;

  trig_coef_lookup u_lookup (
    .angle   (in_angle),
    .func    (in_func),
    .coef    (lk_coef),
    .special (lk_special),
    .err     (lk_err)
  );

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign shifted  = s2_prod_q >>> FRAC_BITS;
  assign max_p    = PROD_W'(MAX_OUT);
  assign min_p    = -max_p;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_r_d       = s1_r_q;
    s1_coef_d    = s1_coef_q;
    s1_special_d = s1_special_q;
    s1_err_d     = s1_err_q;
    s1_tag_d     = s1_tag_q;
    s2_valid_d   = s2_valid_q;
    s2_prod_d    = s2_prod_q;
    s2_rpos_d    = s2_rpos_q;
    s2_rneg_d    = s2_rneg_q;
    s2_special_d = s2_special_q;
    s2_err_d     = s2_err_q;
    s2_tag_d     = s2_tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_sat_d    = out_sat_q;
    out_err_d    = out_err_q;

    if (!stall) begin
      s1_valid_d   = in_valid;
      s1_r_d       = in_r;
      s1_coef_d    = lk_coef;
      s1_special_d = lk_special;
      s1_err_d     = lk_err;
      s1_tag_d     = in_tag;

      s2_valid_d   = s1_valid_q;
      s2_prod_d    = PROD_W'(s1_r_q) * PROD_W'(s1_coef_q);
      s2_rneg_d    = s1_r_q[R_WIDTH-1];
      s2_rpos_d    = !s1_r_q[R_WIDTH-1] && (s1_r_q != '0);
      s2_special_d = s1_special_q;
      s2_err_d     = s1_err_q;
      s2_tag_d     = s1_tag_q;

      out_valid_d  = s2_valid_q;
      out_tag_d    = s2_valid_q ? s2_tag_q : '0;
      out_result_d = '0;
      out_sat_d    = 1'b0;
      out_err_d    = 1'b0;
      // Error wins over the tan 90/270 special case, which wins over clamping
      if (s2_valid_q) begin
        if (s2_err_q) begin
          out_err_d = 1'b1;
        end else if (s2_special_q) begin
          out_sat_d    = 1'b1;
          out_result_d = s2_rneg_q ? -MAX_OUT : (s2_rpos_q ? MAX_OUT : '0);
        end else if (shifted > max_p) begin
          out_sat_d    = 1'b1;
          out_result_d = MAX_OUT;
        end else if (shifted < min_p) begin
          out_sat_d    = 1'b1;
          out_result_d = -MAX_OUT;
        end else begin
          out_result_d = shifted[OUT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_r_q       <= '0;
      s1_coef_q    <= '0;
      s1_special_q <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_prod_q    <= '0;
      s2_rpos_q    <= 1'b0;
      s2_rneg_q    <= 1'b0;
      s2_special_q <= 1'b0;
      s2_err_q     <= 1'b0;
      s2_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_sat_q    <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_r_q       <= s1_r_d;
      s1_coef_q    <= s1_coef_d;
      s1_special_q <= s1_special_d;
      s1_err_q     <= s1_err_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_prod_q    <= s2_prod_d;
      s2_rpos_q    <= s2_rpos_d;
      s2_rneg_q    <= s2_rneg_d;
      s2_special_q <= s2_special_d;
      s2_err_q     <= s2_err_d;
      s2_tag_q     <= s2_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_sat_q    <= out_sat_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_sat    = out_sat_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_trig_scale_pipe.sv
// Directed + streaming bench for trig_scale_pipe with a scoreboard of
// expected results built from full-circle reference tables.
module tb_trig_scale_pipe;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [8:0] in_r = '0;
  logic [4:0]        in_angle = '0;
  logic [1:0]        in_func = '0;
  logic [3:0]        in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [10:0] out_result;
  logic [3:0]        out_tag;
  logic              out_sat;
  logic              out_err;

  typedef struct {
    int res;
    int tag;
    int sat;
    int err;
    bit lat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   bp_mode = 1'b0;

  // sin(15k deg) * 2048 rounded, k = 0..23
  int sin24[24] = '{0, 530, 1024, 1448, 1774, 1978, 2048, 1978, 1774, 1448, 1024, 530,
                    0, -530, -1024, -1448, -1774, -1978, -2048, -1978, -1774, -1448, -1024, -530};
  // tan(15k deg) * 2048; entries 6 and 18 are unused (infinite)
  int tan24[24] = '{0, 549, 1182, 2048, 3547, 7643, 0, -7643, -3547, -2048, -1182, -549,
                    0, 549, 1182, 2048, 3547, 7643, 0, -7643, -3547, -2048, -1182, -549};

  int dir_r[9] = '{100, 100, 200, 100, 100, 255, -256, -100, 0};
  int dir_k[9] = '{2, 3, 13, 0, 10, 5, 5, 6, 18};
  int dir_f[9] = '{2, 2, 0, 1, 2, 2, 2, 2, 2};

  trig_scale_pipe #(.R_WIDTH(9), .OUT_WIDTH(11), .TAG_WIDTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_angle   (in_angle),
    .in_func    (in_func),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_sat    (out_sat),
    .out_err    (out_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(int r, int k, int f, int tag, bit lat, int c);
    exp_t e;
    int   coef;
    int   v;
    e.res = 0; e.tag = tag; e.sat = 0; e.err = 0; e.lat = lat; e.cyc = c;
    if (k > 23 || f == 3) begin
      e.err = 1;
      return e;
    end
    if (f == 2 && (k == 6 || k == 18)) begin
      e.sat = 1;
      e.res = (r > 0) ? 1023 : ((r < 0) ? -1023 : 0);
      return e;
    end
    if (f == 0)      coef = sin24[k];
    else if (f == 1) coef = sin24[(k + 6) % 24];
    else             coef = tan24[k];
    v = (r * coef) >>> 11;
    if (v > 1023) begin
      v = 1023; e.sat = 1;
    end else if (v < -1023) begin
      v = -1023; e.sat = 1;
    end
    e.res = v;
    return e;
  endfunction

  task automatic chk(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        sb.delete();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_result", int'(out_result), 0);
        chk("rst_out_tag", int'(out_tag), 0);
        chk("rst_out_flags", int'({out_sat, out_err}), 0);
      end else begin
        chk("in_ready", int'(in_ready), (out_valid && !out_ready) ? 0 : 1);
        if (out_valid && out_ready) begin
          chk("out_expected", sb.size() > 0 ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("OUT tag=%0h result=%0d sat=%0d err=%0d", out_tag, out_result, out_sat, out_err);
            chk("result", int'(out_result), e.res);
            chk("tag", int'(out_tag), e.tag);
            chk("sat", int'(out_sat), e.sat);
            chk("err", int'(out_err), e.err);
            if (e.lat) chk("latency", cyc - e.cyc, 3);
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(int'(in_r), int'(in_angle), int'(in_func), int'(in_tag), !bp_mode, cyc));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int r, input int k, input int f, input int t);
    int g = 0;
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_r     = 9'(r);
    in_angle = 5'(k);
    in_func  = 2'(f);
    in_tag   = 4'(t);
    while (!accepted && g < 200) begin
      @(negedge clock);
      if (in_ready) accepted = 1'b1;
      else begin
        g++;
        tick();
      end
    end
    chk("send_accepted", int'(accepted), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) send(dir_r[i], dir_k[i], dir_f[i], i);
    send(100, 24, 0, 10);
    send(100, 3, 3, 10);
    drain();

    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 24; k++) begin
        send(int'($urandom_range(0, 511)) - 256, k, f, (k + f) % 16);
      end
    end
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 23)),
           int'($urandom_range(0, 2)), i);
    end
    drain();
    bp_mode   = 1'b0;
    out_ready = 1'b1;
    tick();

    send(50, 1, 0, 1);
    send(60, 2, 1, 2);
    send(70, 3, 2, 3);
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("post_reset_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
